u_line_delay_2row: RTL

Two-row line-delay buffer that produces the paired line streams consumed by the 2×2 window stage. It accepts a raster-ordered 8-bit pixel stream and emits, per accepted pixel, the current-row pixel and the pixel at the same column one row earlier, with a qualifying `ce_out`. It sits between the pixel source (background/difference stage) and the 2×2 matrix in the image_process pipeline. Previous-row storage is a circular buffer of `IMG_WIDTH` entries.

---
 rtl/u_line_delay_2row.sv | 115 +++++++++++
 1 files changed

// File: rtl/u_line_delay_2row.sv
// Two-row line delay: emits each accepted pixel alongside the pixel one row above it,
// with raster position and end-of-line/end-of-frame flags, one cycle after acceptance.
module u_line_delay_2row #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned ROW_W      = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             sof,
  input  logic [7:0]       pix_in,
  output logic [7:0]       data_line_0,
  output logic [7:0]       data_line_1,
  output logic             ce_out,
  output logic             first_row,
  output logic [COL_W-1:0] col_out,
  output logic [ROW_W-1:0] row_out,
  output logic             eol,
  output logic             eof
);

  localparam logic [COL_W-1:0] ColLast = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] RowLast = ROW_W'(IMG_HEIGHT - 1);

  logic [7:0]       mem [IMG_WIDTH];
  logic [COL_W-1:0] col_q, col_d, pos_col;
  logic [ROW_W-1:0] row_q, row_d, pos_row;
  logic             at_eol, at_last_row, on_row0;
  logic [7:0]       rd_data;

  logic [7:0]       line0_q, line1_q;
  logic             ce_out_q, first_row_q, eol_q, eof_q;
  logic [COL_W-1:0] col_out_q;
  logic [ROW_W-1:0] row_out_q;

  // A pixel arriving with sof is taken as position (0,0).
  always_comb begin
    pos_col     = sof ? '0 : col_q;
    pos_row     = sof ? '0 : row_q;
    at_eol      = (pos_col == ColLast);
    at_last_row = (pos_row == RowLast);
    on_row0     = (pos_row == '0);
    rd_data     = mem[pos_col];
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (ce) begin
      if (at_eol) begin
        col_d = '0;
        row_d = at_last_row ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end else if (sof) begin
      col_d = '0;
      row_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Not reset: row-0 masking hides stale content. rd_data is sampled before this write lands.
  always_ff @(posedge clk) begin
    if (ce && !rst) begin
      mem[pos_col] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line0_q     <= '0;
      line1_q     <= '0;
      ce_out_q    <= 1'b0;
      first_row_q <= 1'b0;
      col_out_q   <= '0;
      row_out_q   <= '0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      ce_out_q <= ce;
      eol_q    <= ce && at_eol;
      eof_q    <= ce && at_eol && at_last_row;
      if (ce) begin
        line0_q     <= pix_in;
        line1_q     <= on_row0 ? 8'h00 : rd_data;
        first_row_q <= on_row0;
        col_out_q   <= pos_col;
        row_out_q   <= pos_row;
      end
    end
  end

  assign data_line_0 = line0_q;
  assign data_line_1 = line1_q;
  assign ce_out      = ce_out_q;
  assign first_row   = first_row_q;
  assign col_out     = col_out_q;
  assign row_out     = row_out_q;
  assign eol         = eol_q;
  assign eof         = eof_q;

endmodule
